isram_arb: RTL and testbench

Single-port instruction SRAM arbiter between the fetch address generator and the boot/debug loader. It owns the SRAM chip-select, write-enable and address mux, and holds the boot window after reset. It replays any fetch access it denies and keeps the last fetched 64-bit line stable for the fetch stage. It sits between the fetch PC generator and the instruction SRAM macro.

---
 rtl/isram_arb_pkg.sv | 15 +
 rtl/isram_starve_cnt.sv | 25 ++
 rtl/isram_arb.sv | 108 ++++++++++
 tb/tb_isram_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isram_arb_pkg.sv
// isram_arb_pkg: shared encodings and line-width constants for the instruction SRAM arbiter
package isram_arb_pkg;
    localparam int ISRAM_AW = 29;
    localparam int ISRAM_DW = 64;
    localparam int ISRAM_MW = ISRAM_DW / 8;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_FET  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_e;
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/isram_starve_cnt.sv
// isram_starve_cnt: saturating starvation counter for a shared port
// Ports: clk, rst (async, active-high); inc counts one lost cycle; clr restarts
// from zero and wins over inc; at_limit is high while the count equals LIMIT.
module isram_starve_cnt #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam logic [W-1:0] LIM = LIMIT[W-1:0];
    logic [W-1:0] cnt;
    assign at_limit = cnt == LIM;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_limit)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/isram_arb.sv
// isram_arb: single-port instruction SRAM arbiter between fetch and the boot/debug loader
// Ports: clk, cpurst (async, active-high).
//   fetch : fet_cs/fet_adr in; fet_hold, fet_rvalid, fet_rdata (held line) out.
//   loader: ldr_req/we/adr/wdata/wmask/done in; ldr_gnt, ldr_rvalid, ldr_rdata out.
//   sram  : sram_cs/we/adr/wdata/wmask out (combinational grant); sram_rdata in, one cycle late.
module isram_arb
    import isram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                cpurst,
    input  logic                fet_cs,
    input  logic [ISRAM_AW-1:0] fet_adr,
    output logic                fet_hold,
    output logic                fet_rvalid,
    output logic [ISRAM_DW-1:0] fet_rdata,
    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic [ISRAM_AW-1:0] ldr_adr,
    input  logic [ISRAM_DW-1:0] ldr_wdata,
    input  logic [ISRAM_MW-1:0] ldr_wmask,
    input  logic                ldr_done,
    output logic                ldr_gnt,
    output logic                ldr_rvalid,
    output logic [ISRAM_DW-1:0] ldr_rdata,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [ISRAM_AW-1:0] sram_adr,
    output logic [ISRAM_DW-1:0] sram_wdata,
    output logic [ISRAM_MW-1:0] sram_wmask,
    input  logic [ISRAM_DW-1:0] sram_rdata
);
    state_e              state, state_nxt;
    owner_e              owner, owner_nxt;
    logic                fet_pend;
    logic [ISRAM_AW-1:0] fet_pend_adr;
    logic [ISRAM_DW-1:0] line;
    logic                starve_full;
    logic                fet_src;
    logic [ISRAM_AW-1:0] fet_src_adr;
    logic                fet_win;
    logic                ldr_win;

    isram_starve_cnt #(.W(4), .LIMIT(STARVE_MAX)) u_starve (
        .clk      (clk),
        .rst      (cpurst),
        .inc      (ldr_req & ~ldr_win),
        .clr      (ldr_win),
        .at_limit (starve_full)
    );

    // A fresh fet_cs while a replay is pending supersedes the stored address
    // in the same cycle, so a redirect never fetches the stale line.
    always_comb begin
        fet_src     = fet_pend | fet_cs;
        fet_src_adr = fet_cs ? fet_adr : fet_pend_adr;
        ldr_win     = ldr_req & ((state == ST_BOOT) | ~fet_src | starve_full);
        fet_win     = (state == ST_RUN) & fet_src & ~ldr_win;
        state_nxt   = (state == ST_BOOT && ldr_done) ? ST_RUN : state;
        owner_nxt   = fet_win ? OWN_FET : (ldr_win && !ldr_we) ? OWN_LDR : OWN_NONE;
    end

    assign sram_cs    = fet_win | ldr_win;
    assign sram_we    = ldr_win & ldr_we;
    assign sram_adr   = ldr_win ? ldr_adr : fet_src_adr;
    assign sram_wdata = ldr_wdata;
    assign sram_wmask = sram_we ? ldr_wmask : '0;

    assign ldr_gnt    = ldr_win;
    assign fet_hold   = (state == ST_BOOT) | fet_pend | (fet_cs & ~fet_win);
    assign fet_rvalid = owner == OWN_FET;
    assign fet_rdata  = fet_rvalid ? sram_rdata : line;
    assign ldr_rvalid = owner == OWN_LDR;
    assign ldr_rdata  = sram_rdata;

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst)
            state <= ST_BOOT;
        else
            state <= state_nxt;
    end

    // Fetches arriving during BOOT are not latched; the fetch stage is held
    // and re-presents them once RUN begins.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            fet_pend     <= 1'b0;
            fet_pend_adr <= '0;
        end else if (state == ST_RUN && fet_cs && !fet_win) begin
            fet_pend     <= 1'b1;
            fet_pend_adr <= fet_adr;
        end else if (fet_win) begin
            fet_pend     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            owner <= OWN_NONE;
            line  <= '0;
        end else begin
            owner <= owner_nxt;
            if (owner == OWN_FET)
                line <= sram_rdata;
        end
    end
endmodule

// File: tb/tb_isram_arb.sv
// tb_isram_arb: scoreboard bench for isram_arb with a behavioural SRAM macro
module tb_isram_arb;
    logic        clk = 1'b0;
    logic        cpurst;
    logic        fet_cs, fet_hold, fet_rvalid;
    logic [28:0] fet_adr;
    logic [63:0] fet_rdata;
    logic        ldr_req, ldr_we, ldr_done, ldr_gnt, ldr_rvalid;
    logic [28:0] ldr_adr;
    logic [63:0] ldr_wdata, ldr_rdata;
    logic [7:0]  ldr_wmask;
    logic        sram_cs, sram_we;
    logic [28:0] sram_adr;
    logic [63:0] sram_wdata, sram_rdata;
    logic [7:0]  sram_wmask;

    int checks = 0;
    int failures = 0;
    logic [63:0] fq[$];
    logic [63:0] lq[$];
    logic [63:0] mem[logic [28:0]];
    logic [63:0] exp_mem[logic [28:0]];
    logic [63:0] fe, le;

    isram_arb #(.STARVE_MAX(4)) dut (
        .clk(clk), .cpurst(cpurst),
        .fet_cs(fet_cs), .fet_adr(fet_adr), .fet_hold(fet_hold),
        .fet_rvalid(fet_rvalid), .fet_rdata(fet_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adr(ldr_adr),
        .ldr_wdata(ldr_wdata), .ldr_wmask(ldr_wmask), .ldr_done(ldr_done),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [28:0] a);
        return {a, 3'b101, ~a, 3'b010};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w, input logic [7:0] m);
        logic [63:0] r = o;
        for (int b = 0; b < 8; b++)
            if (m[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] sram_rd(input logic [28:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    function automatic logic [63:0] exp_rd(input logic [28:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_adr] = merge(sram_rd(sram_adr), sram_wdata, sram_wmask);
            else sram_rdata <= sram_rd(sram_adr);
        end
    end

    always @(negedge clk) begin
        if (fet_rvalid === 1'b1) begin
            checks++;
            if (fq.size() == 0) begin
                failures++;
                $display("FAIL fet_unexpected_rvalid got=%h exp=none", fet_rdata);
            end else begin
                fe = fq.pop_front();
                if (fet_rdata !== fe) begin
                    failures++;
                    $display("FAIL fet_rdata got=%h exp=%h", fet_rdata, fe);
                end
            end
        end
        if (ldr_rvalid === 1'b1) begin
            checks++;
            if (lq.size() == 0) begin
                failures++;
                $display("FAIL ldr_unexpected_rvalid got=%h exp=none", ldr_rdata);
            end else begin
                le = lq.pop_front();
                if (ldr_rdata !== le) begin
                    failures++;
                    $display("FAIL ldr_rdata got=%h exp=%h", ldr_rdata, le);
                end
            end
        end
    end

    task automatic idle();
        fet_cs = 0; fet_adr = '0; ldr_req = 0; ldr_we = 0; ldr_adr = '0;
        ldr_wdata = '0; ldr_wmask = '0; ldr_done = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cpurst = 1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL rst_fet_hold got=%b exp=1", fet_hold); end
        checks++; if (fet_rvalid !== 1'b0) begin failures++; $display("FAIL rst_fet_rvalid got=%b exp=0", fet_rvalid); end
        checks++; if (ldr_rvalid !== 1'b0) begin failures++; $display("FAIL rst_ldr_rvalid got=%b exp=0", ldr_rvalid); end
        checks++; if (ldr_gnt !== 1'b0) begin failures++; $display("FAIL rst_ldr_gnt got=%b exp=0", ldr_gnt); end
        checks++; if (sram_cs !== 1'b0) begin failures++; $display("FAIL rst_sram_cs got=%b exp=0", sram_cs); end
        checks++; if (fet_rdata !== 64'h0) begin failures++; $display("FAIL rst_fet_rdata got=%h exp=0", fet_rdata); end
        next();
        cpurst = 0;
    endtask

    task automatic test_boot();
        next();
        ldr_req = 1; ldr_we = 1; ldr_adr = '0; ldr_wdata = 64'h1122334455667788; ldr_wmask = 8'hFF;
        fet_cs = 1; fet_adr = 29'h5;
        @(negedge clk);
        checks++; if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL boot_wr_gnt got=%b exp=1", ldr_gnt); end
        checks++; if (sram_we !== 1'b1) begin failures++; $display("FAIL boot_wr_we got=%b exp=1", sram_we); end
        checks++; if (sram_adr !== 29'h0) begin failures++; $display("FAIL boot_wr_adr got=%h exp=0", sram_adr); end
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL boot_hold_wr got=%b exp=1", fet_hold); end
        exp_mem[29'h0] = merge(exp_rd(29'h0), 64'h1122334455667788, 8'hFF);
        next();
        ldr_we = 0; fet_cs = 0;
        @(negedge clk);
        checks++; if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL boot_rd_gnt got=%b exp=1", ldr_gnt); end
        checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL boot_rd_we got=%b exp=0", sram_we); end
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL boot_hold_rd got=%b exp=1", fet_hold); end
        lq.push_back(exp_rd(29'h0));
        next();
        ldr_req = 0; ldr_done = 1;
        @(negedge clk);
        checks++; if (ldr_rvalid !== 1'b1) begin failures++; $display("FAIL boot_ldr_rvalid got=%b exp=1", ldr_rvalid); end
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL boot_hold_done got=%b exp=1", fet_hold); end
        next();
        ldr_done = 0;
        @(negedge clk);
        checks++; if (fet_hold !== 1'b0) begin failures++; $display("FAIL run_hold_drop got=%b exp=0", fet_hold); end
        checks++; if (ldr_rvalid !== 1'b0) begin failures++; $display("FAIL run_ldr_rvalid got=%b exp=0", ldr_rvalid); end
        checks++; if (fet_rvalid !== 1'b0) begin failures++; $display("FAIL run_fet_rvalid got=%b exp=0", fet_rvalid); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            next();
            fet_cs = 1; fet_adr = 29'(16 + i);
            @(negedge clk);
            checks++; if (sram_cs !== 1'b1) begin failures++; $display("FAIL stream_cs[%0d] got=%b exp=1", i, sram_cs); end
            checks++; if (sram_adr !== fet_adr) begin failures++; $display("FAIL stream_adr[%0d] got=%h exp=%h", i, sram_adr, fet_adr); end
            checks++; if (fet_hold !== 1'b0) begin failures++; $display("FAIL stream_hold[%0d] got=%b exp=0", i, fet_hold); end
            if (i > 0) begin
                checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL stream_rvalid[%0d] got=%b exp=1", i, fet_rvalid); end
            end
            fq.push_back(exp_rd(fet_adr));
        end
        next();
        idle();
        @(negedge clk);
        checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL stream_last_rvalid got=%b exp=1", fet_rvalid); end
        checks++; if (sram_cs !== 1'b0) begin failures++; $display("FAIL stream_idle_cs got=%b exp=0", sram_cs); end
        next();
        @(negedge clk);
        checks++; if (fet_rvalid !== 1'b0) begin failures++; $display("FAIL stream_after_rvalid got=%b exp=0", fet_rvalid); end
        checks++; if (fet_rdata !== exp_rd(29'h12)) begin failures++; $display("FAIL stream_line_held got=%h exp=%h", fet_rdata, exp_rd(29'h12)); end
    endtask

    task automatic test_idle_ldr();
        next();
        ldr_req = 1; ldr_we = 1; ldr_adr = 29'h20; ldr_wdata = 64'hDEADBEEFCAFEF00D; ldr_wmask = 8'h0F;
        @(negedge clk);
        checks++; if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL idle_gnt got=%b exp=1", ldr_gnt); end
        checks++; if (sram_we !== 1'b1) begin failures++; $display("FAIL idle_we got=%b exp=1", sram_we); end
        checks++; if (sram_wmask !== 8'h0F) begin failures++; $display("FAIL idle_wmask got=%h exp=0f", sram_wmask); end
        checks++; if (sram_adr !== 29'h20) begin failures++; $display("FAIL idle_adr got=%h exp=20", sram_adr); end
        exp_mem[29'h20] = merge(exp_rd(29'h20), 64'hDEADBEEFCAFEF00D, 8'h0F);
        next();
        idle(); fet_cs = 1; fet_adr = 29'h20;
        @(negedge clk);
        checks++; if (ldr_rvalid !== 1'b0) begin failures++; $display("FAIL idle_wr_no_rvalid got=%b exp=0", ldr_rvalid); end
        checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL idle_fetch_we got=%b exp=0", sram_we); end
        fq.push_back(exp_rd(29'h20));
        next();
        idle();
        @(negedge clk);
        checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL idle_fetch_rvalid got=%b exp=1", fet_rvalid); end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 5; i++) begin
            next();
            ldr_req = 1; ldr_we = 0; ldr_adr = 29'h20; fet_cs = 1; fet_adr = 29'(80 + i);
            @(negedge clk);
            if (i < 4) begin
                checks++; if (ldr_gnt !== 1'b0) begin failures++; $display("FAIL starve_gnt[%0d] got=%b exp=0", i, ldr_gnt); end
                checks++; if (sram_adr !== fet_adr) begin failures++; $display("FAIL starve_adr[%0d] got=%h exp=%h", i, sram_adr, fet_adr); end
                fq.push_back(exp_rd(fet_adr));
            end else begin
                checks++; if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL starve_gnt[%0d] got=%b exp=1", i, ldr_gnt); end
                checks++; if (sram_adr !== 29'h20) begin failures++; $display("FAIL starve_ldr_adr got=%h exp=20", sram_adr); end
                checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL starve_hold_gnt got=%b exp=1", fet_hold); end
                lq.push_back(exp_rd(29'h20));
            end
            if (i > 0) begin
                checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL starve_rvalid[%0d] got=%b exp=1", i, fet_rvalid); end
            end
        end
        next();
        ldr_req = 0;
        @(negedge clk);
        checks++; if (ldr_gnt !== 1'b0) begin failures++; $display("FAIL replay_gnt got=%b exp=0", ldr_gnt); end
        checks++; if (sram_adr !== 29'h54) begin failures++; $display("FAIL replay_adr got=%h exp=54", sram_adr); end
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL replay_hold got=%b exp=1", fet_hold); end
        checks++; if (fet_rvalid !== 1'b0) begin failures++; $display("FAIL replay_rvalid got=%b exp=0", fet_rvalid); end
        checks++; if (fet_rdata !== exp_rd(29'h53)) begin failures++; $display("FAIL replay_line_held got=%h exp=%h", fet_rdata, exp_rd(29'h53)); end
        checks++; if (ldr_rvalid !== 1'b1) begin failures++; $display("FAIL starve_ldr_rvalid got=%b exp=1", ldr_rvalid); end
        fq.push_back(exp_rd(29'h54));
        next();
        fet_adr = 29'h55;
        @(negedge clk);
        checks++; if (fet_hold !== 1'b0) begin failures++; $display("FAIL post_replay_hold got=%b exp=0", fet_hold); end
        checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL post_replay_rvalid got=%b exp=1", fet_rvalid); end
        fq.push_back(exp_rd(29'h55));
        next();
        idle();
        @(negedge clk);
        checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL starve_tail_rvalid got=%b exp=1", fet_rvalid); end
    endtask

    task automatic test_overwrite();
        for (int i = 0; i < 5; i++) begin
            next();
            ldr_req = 1; ldr_we = 1; ldr_adr = 29'h60; ldr_wdata = 64'h0123456789ABCDEF; ldr_wmask = 8'hFF;
            fet_cs = 1; fet_adr = (i < 4) ? 29'(112 + i) : 29'h30;
            @(negedge clk);
            if (i < 4) begin
                checks++; if (ldr_gnt !== 1'b0) begin failures++; $display("FAIL ovw_gnt[%0d] got=%b exp=0", i, ldr_gnt); end
                fq.push_back(exp_rd(fet_adr));
            end else begin
                checks++; if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL ovw_gnt[%0d] got=%b exp=1", i, ldr_gnt); end
                checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL ovw_hold_deny got=%b exp=1", fet_hold); end
                exp_mem[29'h60] = merge(exp_rd(29'h60), 64'h0123456789ABCDEF, 8'hFF);
            end
        end
        next();
        ldr_req = 0; fet_adr = 29'h40;
        @(negedge clk);
        checks++; if (sram_adr !== 29'h40) begin failures++; $display("FAIL ovw_replay_adr got=%h exp=40", sram_adr); end
        checks++; if (sram_cs !== 1'b1) begin failures++; $display("FAIL ovw_replay_cs got=%b exp=1", sram_cs); end
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL ovw_replay_hold got=%b exp=1", fet_hold); end
        checks++; if (fet_rvalid !== 1'b0) begin failures++; $display("FAIL ovw_wr_no_rvalid got=%b exp=0", fet_rvalid); end
        fq.push_back(exp_rd(29'h40));
        next();
        fet_adr = 29'h60;
        @(negedge clk);
        checks++; if (sram_adr !== 29'h60) begin failures++; $display("FAIL ovw_next_adr got=%h exp=60", sram_adr); end
        checks++; if (fet_hold !== 1'b0) begin failures++; $display("FAIL ovw_next_hold got=%b exp=0", fet_hold); end
        checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL ovw_replay_rvalid got=%b exp=1", fet_rvalid); end
        fq.push_back(exp_rd(29'h60));
        next();
        idle();
        @(negedge clk);
        checks++; if (fet_rvalid !== 1'b1) begin failures++; $display("FAIL ovw_tail_rvalid got=%b exp=1", fet_rvalid); end
        checks++; if (sram_cs !== 1'b0) begin failures++; $display("FAIL ovw_no_stale_replay got=%b exp=0", sram_cs); end
    endtask

    task automatic test_reset_mid();
        next();
        ldr_req = 1; ldr_we = 0; ldr_adr = 29'h0;
        @(negedge clk);
        checks++; if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%b exp=1", ldr_gnt); end
        next();
        idle(); cpurst = 1;
        @(negedge clk);
        checks++; if (ldr_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_ldr_rvalid got=%b exp=0", ldr_rvalid); end
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL rmid_hold got=%b exp=1", fet_hold); end
        next();
        cpurst = 0;
        @(negedge clk);
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL rmid_boot_hold got=%b exp=1", fet_hold); end
        next();
        fet_cs = 1; fet_adr = 29'h10; ldr_req = 1; ldr_we = 0; ldr_adr = 29'h20;
        @(negedge clk);
        checks++; if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL rmid_boot_gnt got=%b exp=1", ldr_gnt); end
        checks++; if (sram_adr !== 29'h20) begin failures++; $display("FAIL rmid_boot_adr got=%h exp=20", sram_adr); end
        checks++; if (fet_hold !== 1'b1) begin failures++; $display("FAIL rmid_boot_hold2 got=%b exp=1", fet_hold); end
        lq.push_back(exp_rd(29'h20));
        next();
        idle(); ldr_done = 1;
        @(negedge clk);
        checks++; if (ldr_rvalid !== 1'b1) begin failures++; $display("FAIL rmid_ldr_rvalid2 got=%b exp=1", ldr_rvalid); end
        checks++; if (fet_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_fet_rvalid got=%b exp=0", fet_rvalid); end
        next();
        idle();
        @(negedge clk);
        checks++; if (fet_hold !== 1'b0) begin failures++; $display("FAIL rmid_run_hold got=%b exp=0", fet_hold); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_boot();
        test_stream();
        test_idle_ldr();
        test_starve();
        test_overwrite();
        test_reset_mid();
        next();
        checks++;
        if (fq.size() != 0 || lq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=fet:%0d,ldr:%0d exp=0,0", fq.size(), lq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
